// File: rtl/mem_arbiter_pkg.sv
// Shared types, widths and helpers for the multi-master byte memory controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned BYTE_W = 8;

    // True when addr falls in the write-protected window starting at rom_base.
    function automatic logic is_rom(input logic [31:0] addr, input logic [31:0] rom_base);
        return addr >= rom_base;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Per-channel request/response bundle between the masters and the memory controller.
interface mem_arbiter_if
    import mem_pkg::*;
#(
    parameter int unsigned CH     = 2,
    parameter int unsigned ADDR_W = 20
);
    logic [CH-1:0]        req;
    logic [CH-1:0]        wreq;
    logic [CH*ADDR_W-1:0] address;
    logic [CH*BYTE_W-1:0] data;
    logic [CH*BYTE_W-1:0] bus;
    logic [CH-1:0]        locked;

    modport master (output req, wreq, address, data, input bus, locked);
    modport slave  (input req, wreq, address, data, output bus, locked);
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin grant: search begins at the channel after the one-hot 'last' grant.
module rr_arbiter #(
    parameter int unsigned CH = 2
) (
    input  logic [CH-1:0] req,
    input  logic [CH-1:0] last,
    input  logic          enable,
    output logic [CH-1:0] grant
);
    int unsigned   last_idx;
    int unsigned   idx;
    logic [CH-1:0] mask;

    // Walk from farthest to nearest so the closest requester after 'last' wins.
    always_comb begin
        last_idx = 0;
        idx      = 0;
        mask     = '0;
        grant    = '0;
        for (int i = 0; i < int'(CH); i++) begin
            if (last[i]) last_idx = i;
        end
        if (enable) begin
            for (int k = int'(CH); k >= 1; k--) begin
                idx  = (last_idx + k) % CH;
                mask = CH'(1) << idx;
                if ((req & mask) != '0) grant = mask;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CH masters onto one byte-wide synchronous array with wait states
// and a write-protected ROM window at the top of the address space.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 20,
    parameter int unsigned       CH       = 2,
    parameter int unsigned       WAIT     = 0,
    parameter logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(20'hF0000),
    parameter string             ROM_FILE = "bios.hex",
    parameter string             RAM_FILE = "mem.hex"
) (
    input  logic          clock,
    input  logic          resetn,
    mem_arbiter_if.slave  mif
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_t                state, state_nx;
    logic [CH-1:0]         grant_c;
    logic [CH-1:0]         last_q, last_nx;
    logic [CH-1:0]         gnt_q, gnt_nx;
    logic [ADDR_W-1:0]     addr_q, addr_nx;
    logic [BYTE_W-1:0]     wdata_q, wdata_nx;
    logic                  wr_q, wr_nx;
    logic [WAIT_W-1:0]     cnt_q, cnt_nx;
    logic [CH-1:0]         locked_q, locked_nx;
    logic [CH*BYTE_W-1:0]  bus_q, bus_nx;
    logic [BYTE_W-1:0]     rd_q;
    logic                  access_c;
    logic [BYTE_W-1:0]     mem [DEPTH];

    rr_arbiter #(.CH(CH)) u_rr (
        .req    (mif.req),
        .last   (last_q),
        .enable (state == IDLE),
        .grant  (grant_c)
    );

    always_comb begin
        state_nx  = state;
        last_nx   = last_q;
        gnt_nx    = gnt_q;
        addr_nx   = addr_q;
        wdata_nx  = wdata_q;
        wr_nx     = wr_q;
        cnt_nx    = cnt_q;
        locked_nx = '0;
        bus_nx    = bus_q;
        access_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_c != '0) begin
                    gnt_nx  = grant_c;
                    last_nx = grant_c;
                    for (int i = 0; i < int'(CH); i++) begin
                        if (grant_c[i]) begin
                            addr_nx  = mif.address[i*ADDR_W +: ADDR_W];
                            wdata_nx = mif.data[i*BYTE_W +: BYTE_W];
                            wr_nx    = mif.wreq[i];
                        end
                    end
                    cnt_nx   = WAIT_W'(WAIT);
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_nx = cnt_q - WAIT_W'(1);
                end else begin
                    access_c = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                locked_nx = gnt_q;
                if (!wr_q) begin
                    for (int i = 0; i < int'(CH); i++) begin
                        if (gnt_q[i]) bus_nx[i*BYTE_W +: BYTE_W] = rd_q;
                    end
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reset points 'last' at the top channel so the first search starts at channel 0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            last_q   <= CH'(1) << (CH - 1);
            gnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            locked_q <= '0;
            bus_q    <= '0;
        end else begin
            state    <= state_nx;
            last_q   <= last_nx;
            gnt_q    <= gnt_nx;
            addr_q   <= addr_nx;
            wdata_q  <= wdata_nx;
            wr_q     <= wr_nx;
            cnt_q    <= cnt_nx;
            locked_q <= locked_nx;
            bus_q    <= bus_nx;
        end
    end

    // Array port: writes into the ROM window are dropped silently.
    always_ff @(posedge clock) begin
        if (access_c) begin
            if (wr_q) begin
                if (!is_rom(32'(addr_q), 32'(ROM_BASE))) mem[addr_q] <= wdata_q;
            end else begin
                rd_q <= mem[addr_q];
            end
        end
    end

    assign mif.locked = locked_q;
    assign mif.bus    = bus_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (WAIT 0/3/4) checked every cycle against a
// transaction-level model, plus directed latency/data/arbitration/reset expectations.
module tb_mem_arbiter;

    localparam int MB = 1 << 20;

    logic clock;
    logic rst_a, rst_b, rst_c;

    mem_arbiter_if #(.CH(2), .ADDR_W(20)) ifa ();
    mem_arbiter_if #(.CH(2), .ADDR_W(20)) ifb ();
    mem_arbiter_if #(.CH(2), .ADDR_W(20)) ifc ();

    mem_arbiter #(.ADDR_W(20), .CH(2), .WAIT(0), .ROM_BASE(20'hF0000),
                  .ROM_FILE(""), .RAM_FILE("")) dut_a (.clock(clock), .resetn(rst_a), .mif(ifa));
    mem_arbiter #(.ADDR_W(20), .CH(2), .WAIT(3), .ROM_BASE(20'hF0000),
                  .ROM_FILE(""), .RAM_FILE("")) dut_b (.clock(clock), .resetn(rst_b), .mif(ifb));
    mem_arbiter #(.ADDR_W(20), .CH(2), .WAIT(4), .ROM_BASE(20'hF0000),
                  .ROM_FILE(""), .RAM_FILE("")) dut_c (.clock(clock), .resetn(rst_c), .mif(ifc));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests;
    int n_fail;

    // ---------------- accessors per instance ----------------
    function automatic logic [1:0] lk(input int k);
        case (k)
            0:       return ifa.locked;
            1:       return ifb.locked;
            default: return ifc.locked;
        endcase
    endfunction

    function automatic logic [15:0] bs(input int k);
        case (k)
            0:       return ifa.bus;
            1:       return ifb.bus;
            default: return ifc.bus;
        endcase
    endfunction

    function automatic logic [1:0] rq(input int k);
        case (k)
            0:       return ifa.req;
            1:       return ifb.req;
            default: return ifc.req;
        endcase
    endfunction

    function automatic logic [1:0] wq(input int k);
        case (k)
            0:       return ifa.wreq;
            1:       return ifb.wreq;
            default: return ifc.wreq;
        endcase
    endfunction

    function automatic logic [39:0] ad(input int k);
        case (k)
            0:       return ifa.address;
            1:       return ifb.address;
            default: return ifc.address;
        endcase
    endfunction

    function automatic logic [15:0] dt(input int k);
        case (k)
            0:       return ifa.data;
            1:       return ifb.data;
            default: return ifc.data;
        endcase
    endfunction

    function automatic logic rn(input int k);
        case (k)
            0:       return rst_a;
            1:       return rst_b;
            default: return rst_c;
        endcase
    endfunction

    function automatic int wait_of(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    longint       cyc;
    int           m_start  [3];
    bit           m_busy   [3];
    int           m_ch     [3];
    bit           m_wr     [3];
    logic [19:0]  m_addr   [3];
    logic [7:0]   m_wdat   [3];
    logic [7:0]   m_rd     [3];
    longint       m_t_acc  [3];
    longint       m_t_done [3];
    logic [1:0]   m_locked [3];
    logic [15:0]  m_bus    [3];
    logic [7:0]   shadow   [int];

    task automatic model_reset(input int k);
        m_busy[k]   = 1'b0;
        m_start[k]  = 0;
        m_locked[k] = 2'b00;
        m_bus[k]    = 16'h0000;
    endtask

    // A granted request completes WAIT+2 edges later; the array is touched one edge earlier.
    task automatic model_edge(input int k);
        logic [1:0]  r;
        logic [39:0] a;
        logic [15:0] d;
        logic [1:0]  w;
        int          c;
        int          key;
        if (!rn(k)) return;
        m_locked[k] = 2'b00;
        if (m_busy[k]) begin
            key = k * MB + int'(m_addr[k]);
            if (cyc == m_t_acc[k]) begin
                if (!m_wr[k]) m_rd[k] = shadow.exists(key) ? shadow[key] : 8'h00;
                else if (m_addr[k] < 20'hF0000) shadow[key] = m_wdat[k];
            end
            if (cyc == m_t_done[k]) begin
                m_locked[k][m_ch[k]] = 1'b1;
                if (!m_wr[k]) m_bus[k][m_ch[k]*8 +: 8] = m_rd[k];
                m_busy[k] = 1'b0;
            end
        end else begin
            r = rq(k);
            if (r != 2'b00) begin
                a = ad(k);
                d = dt(k);
                w = wq(k);
                c = -1;
                for (int i = 0; i < 2; i++) begin
                    if (c < 0 && r[(m_start[k] + i) % 2]) c = (m_start[k] + i) % 2;
                end
                m_ch[k]     = c;
                m_wr[k]     = w[c];
                m_addr[k]   = a[c*20 +: 20];
                m_wdat[k]   = d[c*8 +: 8];
                m_start[k]  = (c + 1) % 2;
                m_t_acc[k]  = cyc + wait_of(k) + 1;
                m_t_done[k] = cyc + wait_of(k) + 2;
                m_busy[k]   = 1'b1;
            end
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        for (int k = 0; k < 3; k++) model_edge(k);
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (!rn(k)) model_reset(k);
            check($sformatf("model_locked%0d", k), 32'(lk(k)), 32'(m_locked[k]));
            check($sformatf("model_bus%0d", k), 32'(bs(k)), 32'(m_bus[k]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input int k, input int ch, input logic r, input logic w,
                         input logic [19:0] a, input logic [7:0] d);
        case (k)
            0: begin ifa.req[ch] = r; ifa.wreq[ch] = w; ifa.address[ch*20 +: 20] = a; ifa.data[ch*8 +: 8] = d; end
            1: begin ifb.req[ch] = r; ifb.wreq[ch] = w; ifb.address[ch*20 +: 20] = a; ifb.data[ch*8 +: 8] = d; end
            default: begin ifc.req[ch] = r; ifc.wreq[ch] = w; ifc.address[ch*20 +: 20] = a; ifc.data[ch*8 +: 8] = d; end
        endcase
    endtask

    task automatic drop(input int k, input int ch);
        case (k)
            0:       ifa.req[ch] = 1'b0;
            1:       ifb.req[ch] = 1'b0;
            default: ifc.req[ch] = 1'b0;
        endcase
    endtask

    // lat = index of the edge (edge 0 = req sample) after which locked[ch] is seen; -1 on timeout.
    task automatic wait_lock(input int k, input int ch, input int start, input int budget, output int lat);
        logic [1:0] l;
        lat = -1;
        for (int n = start; n < start + budget; n++) begin
            @(posedge clock);
            @(negedge clock);
            l = lk(k);
            if (l[ch]) begin
                lat = n;
                drop(k, ch);
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          lat;
        int          g;
        int          c;
        int          order [4];
        logic [1:0]  l;
        logic [15:0] b;

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.req = '0; ifa.wreq = '0; ifa.address = '0; ifa.data = '0;
        ifb.req = '0; ifb.wreq = '0; ifb.address = '0; ifb.data = '0;
        ifc.req = '0; ifc.wreq = '0; ifc.address = '0; ifc.data = '0;
        for (int k = 0; k < 3; k++) model_reset(k);

        dut_a.mem[20'h00010] = 8'h5A;
        dut_a.mem[20'h00011] = 8'h3C;
        dut_b.mem[20'hFFFF0] = 8'hEA;
        shadow[0*MB + 32'h00010] = 8'h5A;
        shadow[0*MB + 32'h00011] = 8'h3C;
        shadow[1*MB + 32'hFFFF0] = 8'hEA;

        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_locked%0d", k), 32'(lk(k)), 32'h0);
            check($sformatf("reset_bus%0d", k), 32'(bs(k)), 32'h0);
        end

        // Single read, WAIT=0
        sync();
        drive(0, 0, 1'b1, 1'b0, 20'h00010, 8'h00);
        wait_lock(0, 0, 0, 10, lat);
        check("rd_latency_w0", 32'(lat), 32'd2);
        b = bs(0);
        check("rd_bus", 32'(b[7:0]), 32'h5A);
        repeat (3) @(negedge clock);
        b = bs(0);
        check("rd_bus_hold", 32'(b[7:0]), 32'h5A);
        check("rd_locked_single", 32'(lk(0)), 32'h0);

        // Arbitration from a fresh pointer: both channels held high
        sync();
        rst_a = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        rst_a = 1'b1;
        sync();
        drive(0, 0, 1'b1, 1'b0, 20'h00010, 8'h00);
        drive(0, 1, 1'b1, 1'b0, 20'h00011, 8'h00);
        g = 0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        for (int n = 0; n < 40 && g < 4; n++) begin
            @(negedge clock);
            l = lk(0);
            if (l != 2'b00) begin
                check("arb_onehot", 32'($countones(l)), 32'd1);
                c = l[1] ? 1 : 0;
                order[g] = c;
                g++;
                b = bs(0);
                check("arb_own_bus", 32'(c == 0 ? b[7:0] : b[15:8]), 32'(c == 0 ? 8'h5A : 8'h3C));
                if (g == 4) begin
                    drop(0, 0);
                    drop(0, 1);
                end
            end
        end
        drop(0, 0);
        drop(0, 1);
        check("arb_grant_count", 32'(g), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("arb_order%0d", i), 32'(order[i]), 32'(i % 2));

        // Wait states, WAIT=3: write then read back
        sync();
        drive(1, 0, 1'b1, 1'b1, 20'h00400, 8'hC3);
        wait_lock(1, 0, 0, 20, lat);
        check("wr_latency_w3", 32'(lat), 32'd5);
        sync();
        drive(1, 0, 1'b1, 1'b0, 20'h00400, 8'h00);
        wait_lock(1, 0, 0, 20, lat);
        check("rd_latency_w3", 32'(lat), 32'd5);
        b = bs(1);
        check("rd_back_c3", 32'(b[7:0]), 32'hC3);

        // ROM window: write discarded, still completes
        sync();
        drive(1, 0, 1'b1, 1'b1, 20'hFFFF0, 8'h00);
        wait_lock(1, 0, 0, 20, lat);
        check("rom_wr_latency", 32'(lat), 32'd5);
        sync();
        drive(1, 0, 1'b1, 1'b0, 20'hFFFF0, 8'h00);
        wait_lock(1, 0, 0, 20, lat);
        b = bs(1);
        check("rom_rd_ea", 32'(b[7:0]), 32'hEA);

        // req dropped mid-ACCESS, WAIT=4: write still lands
        sync();
        drive(2, 1, 1'b1, 1'b1, 20'h00020, 8'h77);
        @(posedge clock);
        @(posedge clock);
        #2;
        drop(2, 1);
        wait_lock(2, 1, 2, 20, lat);
        check("drop_latency_w4", 32'(lat), 32'd6);
        sync();
        drive(2, 1, 1'b1, 1'b0, 20'h00020, 8'h00);
        wait_lock(2, 1, 0, 20, lat);
        check("drop_rd_latency", 32'(lat), 32'd6);
        b = bs(2);
        check("drop_write_landed", 32'(b[15:8]), 32'h77);

        // Reset during ACCESS: write lost, outputs cleared
        sync();
        drive(2, 1, 1'b1, 1'b1, 20'h00020, 8'h11);
        @(posedge clock);
        @(posedge clock);
        #2;
        rst_c = 1'b0;
        drop(2, 1);
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            check("rst_locked", 32'(lk(2)), 32'h0);
            check("rst_bus", 32'(bs(2)), 32'h0);
        end
        sync();
        rst_c = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            check("no_lock_after_rst", 32'(lk(2)), 32'h0);
        end
        sync();
        drive(2, 1, 1'b1, 1'b0, 20'h00020, 8'h00);
        wait_lock(2, 1, 0, 20, lat);
        check("rst_rd_latency", 32'(lat), 32'd6);
        b = bs(2);
        check("rst_write_lost", 32'(b[15:8]), 32'h77);

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
